// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller of the async FIFO (read clock domain)
// Owns the binary read pointer, publishes a registered Gray pointer, derives status flags.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AE_THRESH  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RINC,
   input  logic [ADDR_WIDTH:0]   rq2_wptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic                  EMPTY,
   output logic                  ALMOST_EMPTY,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  RD_VALID,
   output logic                  UNDERFLOW
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] rd_count_q, rd_count_d;
   logic          empty_q, empty_d;
   logic          almost_empty_q, almost_empty_d;
   logic          rd_valid_q, rd_valid_d;
   logic          underflow_q, underflow_d;

   logic          rd_en;
   logic [PW-1:0] wbin;

   always_comb begin
      wbin = '0;
      wbin[PW-1] = rq2_wptr[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         wbin[i] = wbin[i+1] ^ rq2_wptr[i];
      end
   end

   // Flags use the post-read pointer so the last read sets EMPTY on the same edge.
   always_comb begin
      rd_en          = RINC & ~empty_q;
      rbin_d         = rbin_q + PW'(rd_en);
      rptr_d         = (rbin_d >> 1) ^ rbin_d;
      empty_d        = (rptr_d == rq2_wptr);
      rd_count_d     = wbin - rbin_d;
      almost_empty_d = (rd_count_d <= AE_LIMIT);
      rd_valid_d     = rd_en;
      underflow_d    = RINC & empty_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rbin_q         <= '0;
         rptr_q         <= '0;
         rd_count_q     <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         rd_valid_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         rbin_q         <= rbin_d;
         rptr_q         <= rptr_d;
         rd_count_q     <= rd_count_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         rd_valid_q     <= rd_valid_d;
         underflow_q    <= underflow_d;
      end
   end

   assign raddr        = rbin_q[ADDR_WIDTH-1:0];
   assign rptr         = rptr_q;
   assign EMPTY        = empty_q;
   assign ALMOST_EMPTY = almost_empty_q;
   assign rd_count     = rd_count_q;
   assign RD_VALID     = rd_valid_q;
   assign UNDERFLOW    = underflow_q;

endmodule
